// File: rtl/fetchq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Used by fetchq_ram and fetch_queue.
package fetchq_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
    localparam int          FETCHQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } fetchq_entry_t;

endpackage

// File: rtl/fetchq_ram.sv
// Fetch queue storage: DEPTH x 64-bit register array.
// One synchronous write port, one asynchronous read port, data array not reset.
module fetchq_ram
    import fetchq_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IFU and decode: circular buffer with wrap-bit pointers.
// Define FETCHQ_BYPASS_EN to forward an input straight to decode when the queue is empty.
module fetch_queue
    import fetchq_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc4,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc4,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          empty, full;
    logic          bypass, push, pop;
    fetchq_entry_t wr_entry, rd_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // in_ready comes only from registered pointers, so out_ready never reaches the IFU stall.
    assign in_ready = ~full;
    assign count    = wr_ptr_q - rd_ptr_q;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty & in_valid & out_ready & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed input is consumed directly by decode and never occupies a slot.
    assign push = in_valid & in_ready & ~flush & ~bypass;
    assign pop  = ~empty & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_entry.pc4   = in_pc4;
    assign wr_entry.instr = in_instr;

    fetchq_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_entry)
    );

    // Invalid head shows a NOP bubble rather than stale array contents.
    always_comb begin
        out_valid = ~empty;
        out_pc4   = rd_entry.pc4;
        out_instr = rd_entry.instr;
        if (bypass) begin
            out_valid = 1'b1;
            out_pc4   = in_pc4;
            out_instr = in_instr;
        end
        if (!out_valid) begin
            out_pc4   = NOP_INSTR;
            out_instr = NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus hand-written wrap and bypass sequences.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc4;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        int          ecnt;
        logic        eov;
        logic        eir;
        logic [31:0] epc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {16'h2400, pc[15:0]};
    endfunction

    function automatic void add(input logic iv, input logic [31:0] pc, input logic ordy,
                                input logic fl, input int ecnt, input logic eov,
                                input logic eir, input logic [31:0] epc);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.ecnt = ecnt; v.eov = eov; v.eir = eir; v.epc = epc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_pc4    = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic check_outs(input string tag, input int ecnt, input logic eov,
                              input logic eir, input logic [31:0] epc, input logic [31:0] eins);
        chk({tag, ".count"},     {29'd0, count},     ecnt);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, eov});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, eir});
        chk({tag, ".out_pc4"},   out_pc4,            epc);
        chk({tag, ".out_instr"}, out_instr,          eins);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc4 = '0; in_instr = '0; out_ready = 1'b0;

        // Fill to capacity, refused fifth push, drain in order.
        add(0, 32'h0,    0, 0, 0, 0, 1, 32'h0);
        add(1, 32'h3004, 0, 0, 0, 0, 1, 32'h0);
        add(1, 32'h3008, 0, 0, 1, 1, 1, 32'h3004);
        add(1, 32'h300C, 0, 0, 2, 1, 1, 32'h3004);
        add(1, 32'h3010, 0, 0, 3, 1, 1, 32'h3004);
        add(1, 32'h3014, 0, 0, 4, 1, 0, 32'h3004);
        add(0, 32'h0,    1, 0, 4, 1, 0, 32'h3004);
        add(0, 32'h0,    1, 0, 3, 1, 1, 32'h3008);
        add(0, 32'h0,    1, 0, 2, 1, 1, 32'h300C);
        add(0, 32'h0,    1, 0, 1, 1, 1, 32'h3010);
        add(0, 32'h0,    0, 0, 0, 0, 1, 32'h0);
        // Full with simultaneous pop: push refused, accepted next cycle.
        add(1, 32'h5004, 0, 0, 0, 0, 1, 32'h0);
        add(1, 32'h5008, 0, 0, 1, 1, 1, 32'h5004);
        add(1, 32'h500C, 0, 0, 2, 1, 1, 32'h5004);
        add(1, 32'h5010, 0, 0, 3, 1, 1, 32'h5004);
        add(1, 32'h5014, 1, 0, 4, 1, 0, 32'h5004);
        add(1, 32'h5014, 0, 0, 3, 1, 1, 32'h5008);
        add(0, 32'h0,    1, 0, 4, 1, 0, 32'h5008);
        add(0, 32'h0,    1, 0, 3, 1, 1, 32'h500C);
        add(0, 32'h0,    1, 0, 2, 1, 1, 32'h5010);
        add(0, 32'h0,    1, 0, 1, 1, 1, 32'h5014);
        add(0, 32'h0,    0, 0, 0, 0, 1, 32'h0);
        // Flush with a same-cycle push, then redirected fetch.
        add(1, 32'h6004, 0, 0, 0, 0, 1, 32'h0);
        add(1, 32'h6008, 0, 0, 1, 1, 1, 32'h6004);
        add(1, 32'h600C, 0, 0, 2, 1, 1, 32'h6004);
        add(1, 32'h3020, 1, 1, 3, 1, 1, 32'h6004);
        add(1, 32'h4004, 0, 0, 0, 0, 1, 32'h0);
        add(0, 32'h0,    1, 0, 1, 1, 1, 32'h4004);
        add(0, 32'h0,    0, 0, 0, 0, 1, 32'h0);

        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, 0, 1, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].pc, mk_instr(vecs[i].pc), vecs[i].ordy, vecs[i].fl);
            check_outs($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].eov, vecs[i].eir,
                       vecs[i].epc, vecs[i].eov ? mk_instr(vecs[i].epc) : 32'h0);
        end

        // Continuous push and pop across several pointer wraps with one entry resident.
        drive(1, 32'h7004, mk_instr(32'h7004), 0, 0);
        exp_q.push_back(32'h7004);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] pc;
            logic [31:0] head;
            pc = 32'h7008 + 32'(4 * i);
            drive(1, pc, mk_instr(pc), 1, 0);
            head = exp_q.pop_front();
            check_outs($sformatf("wrap%0d", i), 1, 1, 1, head, mk_instr(head));
            exp_q.push_back(pc);
        end
        drive(0, 32'h0, 32'h0, 1, 0);
        begin
            logic [31:0] head;
            head = exp_q.pop_front();
            check_outs("wrap_tail", 1, 1, 1, head, mk_instr(head));
        end
        drive(0, 32'h0, 32'h0, 0, 0);
        check_outs("wrap_empty", 0, 0, 1, 32'h0, 32'h0);

`ifdef FETCHQ_BYPASS_EN
        drive(1, 32'h8004, 32'h2402_0005, 1, 0);
        check_outs("bypass", 0, 1, 1, 32'h8004, 32'h2402_0005);
        drive(0, 32'h0, 32'h0, 0, 0);
        check_outs("bypass_after", 0, 0, 1, 32'h0, 32'h0);
`else
        // Without bypass the same stimulus only lands in storage one cycle later.
        drive(1, 32'h8004, 32'h2402_0005, 1, 0);
        check_outs("nobypass", 0, 0, 1, 32'h0, 32'h0);
        drive(0, 32'h0, 32'h0, 0, 0);
        check_outs("nobypass_after", 1, 1, 1, 32'h8004, 32'h2402_0005);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
